// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute sequencer sitting in front of the register
// bank. Owns the program counter, tracks the FETCH/EXEC/HALT phase, decodes
// the latched instruction byte and drives the 15-bit control word.
//
// Ports:
//   clk          system clock, state updates on posedge
//   reset        asynchronous active-low reset
//   run          1 = may start the next fetch, 0 = stall in FETCH
//   ir           instruction byte latched by the register bank
//   flagCarry    carry flag from the register bank (JC condition)
//   dbus         data bus, source of jump targets
//   controlBits  [14:0] = loadIR, loadPC, loadA, loadB, loadX, doOut,
//                storeMem, assertM, assertE, assertA, assertX, immediate,
//                jumpControl, doSubtract, doJump
//   pc           program counter (memory address when immediate=1)
//   halted       high while in HALT
module control_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  ir,
  input  logic        flagCarry,
  input  logic [7:0]  dbus,
  output logic [14:0] controlBits,
  output logic [7:0]  pc,
  output logic        halted
);

  localparam int unsigned B_LOAD_IR  = 14;
  localparam int unsigned B_LOAD_PC  = 13;
  localparam int unsigned B_LOAD_A   = 12;
  localparam int unsigned B_LOAD_B   = 11;
  localparam int unsigned B_LOAD_X   = 10;
  localparam int unsigned B_DO_OUT   = 9;
  localparam int unsigned B_STORE_M  = 8;
  localparam int unsigned B_ASSERT_M = 7;
  localparam int unsigned B_ASSERT_E = 6;
  localparam int unsigned B_ASSERT_A = 5;
  localparam int unsigned B_ASSERT_X = 4;
  localparam int unsigned B_IMM      = 3;
  localparam int unsigned B_JMP_CTL  = 2;
  localparam int unsigned B_SUB      = 1;
  localparam int unsigned B_DO_JUMP  = 0;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [14:0] ctrl;
  logic [2:0]  dest;
  logic [1:0]  src;
  logic        illegal;

  assign dest = ir[7:5];
  assign src  = ir[4:3];

  // Reserved bit set, MEM-to-MEM without immediate, and the HALT opcode all
  // stop the machine without committing anything.
  assign illegal = ir[0] || (dest == 3'b111) ||
                   ((dest == 3'b100) && (src == 2'b11) && !ir[2]);

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_FETCH: begin
        if (run) begin
          ctrl[B_LOAD_IR]  = 1'b1;
          ctrl[B_ASSERT_M] = 1'b1;
          ctrl[B_IMM]      = 1'b1;
          pc_d             = pc_q + 8'd1;
          state_d          = S_EXEC;
        end
      end
      S_EXEC: begin
        if (illegal) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          unique case (dest)
            3'b000: ctrl[B_LOAD_A]  = 1'b1;
            3'b001: ctrl[B_LOAD_B]  = 1'b1;
            3'b010: ctrl[B_LOAD_X]  = 1'b1;
            3'b011: ctrl[B_DO_OUT]  = 1'b1;
            3'b100: ctrl[B_STORE_M] = 1'b1;
            3'b101: begin
              ctrl[B_LOAD_PC] = 1'b1;
              ctrl[B_DO_JUMP] = 1'b1;
            end
            3'b110: begin
              ctrl[B_JMP_CTL] = 1'b1;
              ctrl[B_LOAD_PC] = flagCarry;
              ctrl[B_DO_JUMP] = flagCarry;
            end
            default: ;
          endcase
          if (ir[2]) begin
            ctrl[B_ASSERT_M] = 1'b1;
            ctrl[B_IMM]      = 1'b1;
          end else begin
            unique case (src)
              2'b00: ctrl[B_ASSERT_A] = 1'b1;
              2'b01: ctrl[B_ASSERT_X] = 1'b1;
              2'b10: ctrl[B_ASSERT_E] = 1'b1;
              2'b11: ctrl[B_ASSERT_M] = 1'b1;
            endcase
          end
          ctrl[B_SUB] = ir[1];
          if (ctrl[B_LOAD_PC]) begin
            pc_d = dbus;
          end else if (ir[2]) begin
            pc_d = pc_q + 8'd1;
          end
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Gate with reset so no load strobe leaks out while reset is held low.
  assign controlBits = reset ? ctrl : '0;
  assign pc          = pc_q;
  assign halted      = (state_q == S_HALT);

  always_ff @(posedge clk) begin
    if (reset && (controlBits != '0)) begin
      assert ($onehot({controlBits[B_ASSERT_M], controlBits[B_ASSERT_E],
                       controlBits[B_ASSERT_A], controlBits[B_ASSERT_X]}));
    end
  end

endmodule
